// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
//   Handshake bundle for the two-producer / one-consumer round-robin arbiter.
//   Ports (slave = arbiter view):
//     a_data/a_valid -> a_ready   channel A producer handshake
//     b_data/b_valid -> b_ready   channel B producer handshake
//     out_data/out_valid/out_src  registered arbitrated stream, out_ready from consumer
interface rr_mux_arbiter_if #(
    parameter int N = 8
);
    logic [N-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_src;

    // Producers/consumer side
    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, out_data, out_valid, out_src
    );

    // Arbiter side
    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Two-requester round-robin arbiter driving a shared N-bit 2:1 select path
//   (sel=0 passes A, sel=1 passes B) into one registered output stage.
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     bus          rr_mux_arbiter_if.slave: A/B valid-ready inputs, registered output
//     grant_cnt_a  words accepted from A since reset (wraps)
//     grant_cnt_b  words accepted from B since reset (wraps)
module rr_mux_arbiter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_mux_arbiter_if.slave      bus,
    output logic [15:0]          grant_cnt_a,
    output logic [15:0]          grant_cnt_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic         out_src_q, out_src_d;
    logic         last_src_q, last_src_d;
    logic [15:0]  cnt_a_q, cnt_a_d;
    logic [15:0]  cnt_b_q, cnt_b_d;

    logic load_en;
    logic sel;
    logic a_acc;
    logic b_acc;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        last_src_d = last_src_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;

        load_en = (state_q == EMPTY) || bus.out_ready;

        unique case ({bus.a_valid, bus.b_valid})
            2'b10:   sel = 1'b0;
            2'b01:   sel = 1'b1;
            2'b11:   sel = ~last_src_q;  // tie: whoever did not win last time
            default: sel = 1'b0;
        endcase

        // Reset cycles never complete a handshake.
        a_acc = !rst && load_en && bus.a_valid && !sel;
        b_acc = !rst && load_en && bus.b_valid &&  sel;

        if (a_acc || b_acc) begin
            state_d    = FULL;
            out_data_d = sel ? bus.b_data : bus.a_data;
            out_src_d  = sel;
            last_src_d = sel;
            if (a_acc) cnt_a_d = cnt_a_q + 16'd1;
            if (b_acc) cnt_b_d = cnt_b_q + 16'd1;
        end else if (load_en) begin
            // Drained (or already empty) with nothing to refill; word and priority hold.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            last_src_q <= 1'b1;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            last_src_q <= last_src_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
        end
    end

    assign bus.a_ready   = a_acc;
    assign bus.b_ready   = b_acc;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_src   = out_src_q;
    assign grant_cnt_a   = cnt_a_q;
    assign grant_cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
//   Self-checking bench for rr_mux_arbiter: directed scenarios with literal
//   expectations, a cycle model checked every cycle, and a word scoreboard.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    rr_mux_arbiter_if #(.N(8)) bus ();

    rr_mux_arbiter #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_cnt_a (cnt_a),
        .grant_cnt_b (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words held by the output stage plus words accepted but not yet consumed.
    bit         m_valid = 0;
    logic [7:0] m_data  = 8'h00;
    bit         m_src   = 0;
    bit         m_b_won_last = 1;   // who won the most recent grant
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;
    logic [8:0] sb[$];              // {src, data} in acceptance order

    // Returns {b_granted, a_granted}.
    function automatic logic [1:0] model_grant(input bit full, input bit b_won_last,
                                               input bit av, input bit bv,
                                               input bit ordy, input bit rs);
        if (rs) return 2'b00;
        if (full && !ordy) return 2'b00;          // stalled: nobody may enter
        if (av && bv) return b_won_last ? 2'b01 : 2'b10;
        return {bv, av};
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        g = model_grant(m_valid, m_b_won_last, bus.a_valid, bus.b_valid, bus.out_ready, rst);
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_src = 0; m_b_won_last = 1;
            m_cnt_a = 0; m_cnt_b = 0;
            sb.delete();
        end else if (g != 2'b00) begin
            m_src        = g[1];
            m_data       = g[1] ? bus.b_data : bus.a_data;
            m_valid      = 1;
            m_b_won_last = g[1];
            if (g[1]) m_cnt_b = (m_cnt_b + 1) % 65536;
            else      m_cnt_a = (m_cnt_a + 1) % 65536;
            sb.push_back({m_src, m_data});
        end else if (!m_valid || bus.out_ready) begin
            m_valid = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int a_skip = 0;
    int b_skip = 0;

    always @(negedge clk) begin
        logic [1:0] g;
        logic [8:0] w;
        g = model_grant(m_valid, m_b_won_last, bus.a_valid, bus.b_valid, bus.out_ready, rst);
        chk("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", bus.out_data, m_data);
            chk("out_src", bus.out_src, m_src);
        end
        chk("grant_cnt_a", cnt_a, m_cnt_a);
        chk("grant_cnt_b", cnt_b, m_cnt_b);
        chk("a_ready", bus.a_ready, g[0]);
        chk("b_ready", bus.b_ready, g[1]);

        // Consumed word must be the oldest accepted one.
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow at %0t: got word %0h, expected none", $time, bus.out_data);
            end else begin
                w = sb.pop_front();
                chk("sb_word", {bus.out_src, bus.out_data}, w);
            end
        end

        // A requester may be passed over at most once in a row.
        if (rst || !bus.a_valid || bus.a_ready) a_skip = 0;
        else if (bus.b_ready) begin
            a_skip++;
            chk("fair_a_skip_le1", (a_skip <= 1), 1);
        end
        if (rst || !bus.b_valid || bus.b_ready) b_skip = 0;
        else if (bus.a_ready) begin
            b_skip++;
            chk("fair_b_skip_le1", (b_skip <= 1), 1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.a_valid = 0; bus.b_valid = 0; bus.out_ready = 0;
        bus.a_data = 8'h00; bus.b_data = 8'h00;
        step(); step();
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_out_data", bus.out_data, 8'h00);
        chk("idle_out_src", bus.out_src, 0);
        chk("idle_cnt_a", cnt_a, 0);
        chk("idle_cnt_b", cnt_b, 0);
        chk("idle_a_ready", bus.a_ready, 0);
        chk("idle_b_ready", bus.b_ready, 0);

        // Single requester
        step();
        bus.a_valid = 1; bus.a_data = 8'h5A; bus.out_ready = 1;
        @(negedge clk);
        chk("single_a_ready", bus.a_ready, 1);
        step();
        bus.a_valid = 0;
        @(negedge clk);
        chk("single_out_valid", bus.out_valid, 1);
        chk("single_out_data", bus.out_data, 8'h5A);
        chk("single_out_src", bus.out_src, 0);
        chk("single_cnt_a", cnt_a, 1);

        // Re-arm priority so A wins the first tie
        step();
        rst = 1;
        step();
        rst = 0;
        bus.a_valid = 1; bus.b_valid = 1; bus.a_data = 8'h11; bus.b_data = 8'h22;

        // Tie alternation: A,B,A,B
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tie_a_ready", bus.a_ready, (i % 2 == 0));
            if (i > 0) chk("tie_out_data", bus.out_data, (i % 2 == 1) ? 8'h11 : 8'h22);
            step();
        end
        @(negedge clk);
        chk("tie_out_data_last", bus.out_data, 8'h22);
        chk("tie_out_src_last", bus.out_src, 1);
        chk("tie_cnt_a", cnt_a, 2);
        chk("tie_cnt_b", cnt_b, 2);
        step();                         // A accepted: 0x11 held

        // Back-pressure
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_a_ready", bus.a_ready, 0);
            chk("stall_b_ready", bus.b_ready, 0);
            chk("stall_out_data", bus.out_data, 8'h11);
            chk("stall_out_valid", bus.out_valid, 1);
            step();
        end
        bus.out_ready = 1;
        @(negedge clk);
        chk("unstall_b_ready", bus.b_ready, 1);
        chk("unstall_a_ready", bus.a_ready, 0);
        step();
        @(negedge clk);
        chk("unstall_out_data", bus.out_data, 8'h22);
        chk("unstall_out_src", bus.out_src, 1);
        chk("unstall_cnt_a", cnt_a, 3);
        chk("unstall_cnt_b", cnt_b, 3);

        // Reset mid-operation
        step();
        rst = 1;
        @(negedge clk);
        chk("rstmid_a_ready", bus.a_ready, 0);
        chk("rstmid_b_ready", bus.b_ready, 0);
        chk("rstmid_held", bus.out_valid, 1);
        step();
        rst = 0;
        @(negedge clk);
        chk("rstmid_out_valid", bus.out_valid, 0);
        chk("rstmid_cnt_a", cnt_a, 0);
        chk("rstmid_cnt_b", cnt_b, 0);
        chk("rstmid_a_first", bus.a_ready, 1);
        step();
        @(negedge clk);
        chk("rstmid_out_data", bus.out_data, 8'h11);
        chk("rstmid_out_src", bus.out_src, 0);

        // Counter wrap
        step();
        rst = 1; bus.b_valid = 0;
        step();
        rst = 0;
        for (int i = 0; i < 65535; i++) begin
            bus.a_data = 8'(i);
            step();
        end
        @(negedge clk);
        chk("wrap_cnt_ffff", cnt_a, 16'hFFFF);
        step();
        @(negedge clk);
        chk("wrap_cnt_zero", cnt_a, 16'h0000);
        chk("wrap_cnt_b", cnt_b, 16'h0000);

        // Random soak
        step();
        for (int i = 0; i < 2000; i++) begin
            bus.a_valid   = 1'($urandom_range(0, 1));
            bus.b_valid   = 1'($urandom_range(0, 1));
            bus.a_data    = 8'($urandom);
            bus.b_data    = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain
        bus.a_valid = 0; bus.b_valid = 0; bus.out_ready = 1;
        step(); step();
        @(negedge clk);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_out_valid", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
